// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the sync_fifo block.
// The optional error flags are built only when SYNC_FIFO_ERR_EN is defined.
package sync_fifo_pkg;

    localparam int SYNC_FIFO_DATA_W    = 32;
    localparam int SYNC_FIFO_ADDR_W    = 4;
    // Widest pointer for the legal ADDR_W range (up to 10 bits plus the wrap bit).
    localparam int SYNC_FIFO_PTR_MAX_W = 11;

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

    // Pointer difference at full pointer width; the wrap bit makes this the occupancy.
    function automatic logic [SYNC_FIFO_PTR_MAX_W-1:0] fifo_cnt(
        input logic [SYNC_FIFO_PTR_MAX_W-1:0] wptr,
        input logic [SYNC_FIFO_PTR_MAX_W-1:0] rptr
    );
        return wptr - rptr;
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
// No reset, so it maps directly onto a regfile or SRAM macro.
module sync_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: capture data into the addressed entry.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO using all 2**ADDR_W entries.
// Define SYNC_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = SYNC_FIFO_DATA_W,
    parameter int ADDR_W = SYNC_FIFO_ADDR_W,
    parameter int AF_LVL = 2 ** ADDR_W - 2,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wen_i,
    input  logic              ren_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] AF_CNT  = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_CNT  = AE_LVL[ADDR_W:0];

    logic [ADDR_W:0]              r_wptr;
    logic [ADDR_W:0]              r_rptr;
    logic [SYNC_FIFO_PTR_MAX_W-1:0] w_wptr_ext;
    logic [SYNC_FIFO_PTR_MAX_W-1:0] w_rptr_ext;
    logic [SYNC_FIFO_PTR_MAX_W-1:0] w_cnt_ext;
    logic                         w_unused_cnt;
    logic [ADDR_W:0]              w_cnt;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_rd_acc;
    logic                         w_wr_acc;
    logic                         w_mem_we;
    logic [DATA_W-1:0]            w_rdata;

    // Widen the pointers to the package helper's width and take the occupancy.
    always_comb begin
        w_wptr_ext           = '0;
        w_rptr_ext           = '0;
        w_wptr_ext[ADDR_W:0] = r_wptr;
        w_rptr_ext[ADDR_W:0] = r_rptr;
        w_cnt_ext            = fifo_cnt(w_wptr_ext, w_rptr_ext);
        w_cnt                = w_cnt_ext[ADDR_W:0];
    end

    // The borrow bits above the pointer width carry no information.
    assign w_unused_cnt = ^w_cnt_ext;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                      (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);

    // A read frees a slot this cycle, which is what lets a write land on a full FIFO.
    assign w_rd_acc = ren_i & ~w_empty;
    assign w_wr_acc = wen_i & (~w_full | w_rd_acc);
    assign w_mem_we = w_wr_acc & ~clr_i;

    // Pointer state: flush has priority over any request in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end else begin
                r_rptr <= r_rptr;
            end
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_mem_we),
        .waddr (r_wptr[ADDR_W-1:0]),
        .wdata (data_i),
        .raddr (r_rptr[ADDR_W-1:0]),
        .rdata (w_rdata)
    );

    // Show-ahead head entry, masked to zero when empty so stale storage never leaks out.
    always_comb begin
        if (w_empty) begin
            data_o = '0;
        end else begin
            data_o = w_rdata;
        end
    end

    assign count_o        = w_cnt;
    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign almost_full_o  = (w_cnt >= AF_CNT);
    assign almost_empty_o = (w_cnt <= AE_CNT);

`ifdef SYNC_FIFO_ERR_EN
    fifo_err_t r_err;

    // Sticky misuse flags: a rejected write is overflow, a read on empty is underflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else if (clr_i) begin
            r_err <= '0;
        end else begin
            r_err.ovf <= r_err.ovf | (wen_i & ~w_wr_acc);
            r_err.udf <= r_err.udf | (ren_i & w_empty);
        end
    end

    assign ovf_o = r_err.ovf;
    assign udf_o = r_err.udf;
`else
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (depth 4, AF_LVL 3, AE_LVL 1).
module tb_sync_fifo;

    localparam int DW = 32;
    localparam int AW = 2;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          clr;
    logic          wen;
    logic          ren;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic          afull;
    logic          aempty;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          udf;

    int n_tests;
    int n_fail;

    sync_fifo #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .AF_LVL (3),
        .AE_LVL (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clr_i          (clr),
        .wen_i          (wen),
        .ren_i          (ren),
        .data_i         (din),
        .data_o         (dout),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .count_o        (cnt),
        .ovf_o          (ovf),
        .udf_o          (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wen = 1'b1;
        din = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic pop();
        ren = 1'b1;
        tick();
        ren = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int c, input logic e, input logic f,
                              input logic ae, input logic af);
        check({tag, ".count"}, 32'(cnt), 32'(c));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".full"}, 32'(full), 32'(f));
        check({tag, ".aempty"}, 32'(aempty), 32'(ae));
        check({tag, ".afull"}, 32'(afull), 32'(af));
    endtask

    logic [DW-1:0] fill_vals [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        clr = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        din = 32'h0;
        fill_vals[0] = 32'h11;
        fill_vals[1] = 32'h22;
        fill_vals[2] = 32'h33;
        fill_vals[3] = 32'h44;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk_status("rst0", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rst0.data", dout, 32'h0);
        check("rst0.ovf", 32'(ovf), 32'h0);
        check("rst0.udf", 32'(udf), 32'h0);

        // Asynchronous reset mid-stream with three entries
        push(32'hA1);
        push(32'hA2);
        push(32'hA3);
        chk_status("pre_rst", 3, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_status("async_rst", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("async_rst.data", dout, 32'h0);
        rst = 1'b0;
        tick();

        // Fill and drain
        push(32'h11);
        chk_status("fill1", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("fill1.data", dout, 32'h11);
        push(32'h22);
        chk_status("fill2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'h33);
        chk_status("fill3", 3, 1'b0, 1'b0, 1'b0, 1'b1);
        push(32'h44);
        chk_status("fill4", 4, 1'b0, 1'b1, 1'b0, 1'b1);
        check("fill4.head", dout, 32'h11);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d.data", i), dout, fill_vals[i]);
            pop();
        end
        chk_status("drained", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("drained.data", dout, 32'h0);

        // Write on full together with a read
        for (int i = 0; i < 4; i++) push(fill_vals[i]);
        wen = 1'b1;
        ren = 1'b1;
        din = 32'h55;
        tick();
        wen = 1'b0;
        ren = 1'b0;
        chk_status("wof", 4, 1'b0, 1'b1, 1'b0, 1'b1);
        check("wof.head", dout, 32'h22);
        check("wof.ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wof_drain%0d", i), dout, (i == 3) ? 32'h55 : fill_vals[i + 1]);
            pop();
        end
        check("wof_end.empty", 32'(empty), 32'h1);

        // Pointer wrap with single write/read pairs
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(i));
            check($sformatf("wrap%0d.count", i), 32'(cnt), 32'h1);
            check($sformatf("wrap%0d.data", i), dout, 32'h100 + 32'(i));
            pop();
            check($sformatf("wrap%0d.empty", i), 32'(empty), 32'h1);
        end

        // Flush drops a concurrent write
        push(32'h61);
        push(32'h62);
        push(32'h63);
        check("pre_clr.count", 32'(cnt), 32'h3);
        clr = 1'b1;
        wen = 1'b1;
        din = 32'h99;
        tick();
        clr = 1'b0;
        wen = 1'b0;
        chk_status("clr", 0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("clr.data", dout, 32'h0);
        push(32'hAA);
        check("post_clr.data", dout, 32'hAA);
        check("post_clr.count", 32'(cnt), 32'h1);
        pop();

        // Misuse: write while full, read while empty, then flush
        for (int i = 0; i < 4; i++) push(32'h1 + 32'(i));
        push(32'hEE);
        check("ovf.flag", 32'(ovf), 32'(ERR_EXP));
        check("ovf.count", 32'(cnt), 32'h4);
        check("ovf.head", dout, 32'h1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain%0d", i), dout, 32'h1 + 32'(i));
            pop();
        end
        check("pre_udf.udf", 32'(udf), 32'h0);
        pop();
        check("udf.flag", 32'(udf), 32'(ERR_EXP));
        check("udf.count", 32'(cnt), 32'h0);
        check("udf.ovf_sticky", 32'(ovf), 32'(ERR_EXP));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("err_clr.ovf", 32'(ovf), 32'h0);
        check("err_clr.udf", 32'(udf), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous first-word-fall-through FIFO. It replaces the fixed-width, one-slot-wasting FIFO used by the CPU and DMA/bus bridge paths. All 2**ADDR_W entries are usable. It adds an occupancy count, programmable almost-full/almost-empty thresholds, and write-on-full when a read is accepted in the same cycle. Optional sticky overflow/underflow error flags report misuse by the surrounding handshake logic.

## Interface

**Parameters**

- `DATA_W`, default 32 (`DATA_BITS`): entry width in bits.
- `ADDR_W`, default 4: address width; depth = 2**ADDR_W entries. Legal range is 1..10.
- `AF_LVL`, default 2**ADDR_W-2: `almost_full_o` asserts when count >= AF_LVL. Legal range is 1..2**ADDR_W.
- `AE_LVL`, default 2: `almost_empty_o` asserts when count <= AE_LVL. Legal range is 0..2**ADDR_W-1.

**Ports**

- `clk` input 1: single clock; all state on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `clr_i` input 1: synchronous flush.
- `wen_i` input 1: write request.
- `ren_i` input 1: read request (pop of the head entry).
- `data_i` input DATA_W: write data.
- `data_o` output DATA_W: head entry (show-ahead).
- `full_o` output 1: count == 2**ADDR_W.
- `empty_o` output 1: count == 0.
- `almost_full_o` output 1: count >= AF_LVL.
- `almost_empty_o` output 1: count <= AE_LVL.
- `count_o` output ADDR_W+1: current occupancy, 0..2**ADDR_W.
- `ovf_o` output 1: sticky overflow flag; constant 0 unless `SYNC_FIFO_ERR_EN` is defined.
- `udf_o` output 1: sticky underflow flag; constant 0 unless `SYNC_FIFO_ERR_EN` is defined.

## Operation

**Pointers**
- `wptr` and `rptr` are ADDR_W+1 bits wide. The MSB is the wrap bit and the low ADDR_W bits index storage.
- Both increment modulo 2**(ADDR_W+1).
- count = wptr - rptr, computed at ADDR_W+1 bits.
- full: MSBs differ and low bits are equal. empty: pointers are equal.

**Accept rules**
- rd_acc = ren_i & ~empty_o.
- wr_acc = wen_i & (~full_o | rd_acc).
- Write while full is accepted only together with an accepted read; count is unchanged.
- Read while empty is never accepted, and there is no bypass: a write to an empty FIFO is not readable in the same cycle.
- wr_acc: mem[wptr[ADDR_W-1:0]] <= data_i; wptr++.
- rd_acc: rptr++.

**Output data**
- data_o = empty_o ? 0 : mem[rptr[ADDR_W-1:0]].
- Combinational from registered state only; there is no path from any input.

**Flush and reset**
- `clr_i` has priority over `wen_i` and `ren_i`. Both pointers go to 0 and the error flags clear.
- Storage is not cleared on flush, and it is not reset.

**Reset values**
- Pointers 0, so count_o = 0.
- empty_o = 1, full_o = 0, almost_empty_o = 1.
- almost_full_o = 0 (AF_LVL >= 1).
- data_o = 0, ovf_o = 0, udf_o = 0.
- Reset asserted mid-operation discards all contents immediately and asynchronously.

**Flag derivation**
- All flags and count_o are decoded from the registered pointers and error bits.
- No output depends combinationally on any input.

## Timing

- Write accepted at edge N: empty_o falls, count_o increments, and data_o shows the entry after edge N (visible in cycle N+1).
- Read accepted at edge N: the next entry, or 0 if the FIFO is now empty, appears on data_o after edge N.
- Simultaneous accepted read and write: count_o unchanged. Flags are unchanged, except that with count 1 the head advances to the new entry.
- Pointer wrap from 2**(ADDR_W+1)-1 to 0 is seamless.
- `clr_i` at edge N: all outputs hold their reset values after edge N. Any `wen_i`/`ren_i` in that cycle is dropped.

## Configuration

**`SYNC_FIFO_ERR_EN` defined**
- `ovf_o` sets on any cycle with wen_i & ~wr_acc.
- `udf_o` sets on any cycle with ren_i & empty_o.
- Both are sticky until `rst` or `clr_i`.
- A rejected request is still dropped without side effects.

**`SYNC_FIFO_ERR_EN` undefined**
- Both ports are tied to 0 and no flag flops exist.
- The port list is identical in both builds.

## Structure

**Package `sync_fifo_pkg`**
- Default constants: SYNC_FIFO_DATA_W = 32, SYNC_FIFO_ADDR_W = 4.
- Packed struct `fifo_err_t {ovf, udf}`.
- Function `fifo_cnt(wptr, rptr)` returning the ADDR_W+1-bit difference.

**Sub-module `sync_fifo_mem`**
- Parametrised DATA_W/ADDR_W.
- One synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- No reset, so it can be swapped for an SRAM/regfile macro.
- `sync_fifo` holds the pointers, accept logic, flags and error bits.

## Test plan

Bench parameters: DATA_W=32, ADDR_W=2 (depth 4), AF_LVL=3, AE_LVL=1.

1. **Reset.** Assert `rst` mid-stream with count 3 -> immediately count_o=0, empty_o=1, almost_empty_o=1, data_o=0, full_o=0.
2. **Fill and drain.** Write 0x11, 0x22, 0x33, 0x44 -> full_o=1 after the 4th edge; almost_full_o=1 from count 3; almost_empty_o=0 from count 2. Then 4 reads -> data_o shows 0x11..0x44 in order, then empty_o=1 and data_o=0.
3. **Write on full with read.** Full with head 0x11; wen_i=ren_i=1 with data 0x55 -> count_o stays 4 and the head becomes 0x22. Draining yields 0x22, 0x33, 0x44, 0x55.
4. **Wrap.** 20 single write/read pairs with incrementing data -> every read returns its value and count_o never exceeds 1. The pointers pass 7->0 twice.
5. **Flush.** count 3, `clr_i` with wen_i=1 and data 0x99 -> count_o=0 and empty_o=1. The next write of 0xAA is read back as 0xAA.
6. **Error flags (`SYNC_FIFO_ERR_EN`).**
   - Write while full with no read -> ovf_o=1, count stays 4, and the entry is not written.
   - Read while empty -> udf_o=1.
   - `clr_i` -> both flags 0.
   - Without the macro, both flags stay 0 under the same stimulus.
